// File: rtl/ms_router_nxm.sv
// ms_router_nxm: N-master to M-slave req/ack/resp crossbar; define MS_ROUTER_DECERR_EN to add an error slave for out-of-range addresses
module ms_router_nxm #(
  parameter int N_MST      = 2,
  parameter int N_SLV      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SEL_W      = $clog2(N_SLV)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MST-1:0]              m_req,
  input  logic [N_MST*ADDR_WIDTH-1:0]   m_addr,
  input  logic [N_MST-1:0]              m_cmd,
  input  logic [N_MST*DATA_WIDTH-1:0]   m_wdata,
  output logic [N_MST-1:0]              m_ack,
  output logic [N_MST*DATA_WIDTH-1:0]   m_rdata,
  output logic [N_MST-1:0]              m_resp,
  output logic [N_SLV-1:0]              s_req,
  output logic [N_SLV*ADDR_WIDTH-1:0]   s_addr,
  output logic [N_SLV-1:0]              s_cmd,
  output logic [N_SLV*DATA_WIDTH-1:0]   s_wdata,
  input  logic [N_SLV-1:0]              s_ack,
  input  logic [N_SLV*DATA_WIDTH-1:0]   s_rdata,
  input  logic [N_SLV-1:0]              s_resp
);
  localparam int MW = $clog2(N_MST);
  localparam int CW = $clog2(N_MST + 1);
  typedef enum logic {IDLE, LOCKED} arb_t;
  arb_t             st_q   [N_SLV];
  arb_t             st_d   [N_SLV];
  logic [MW-1:0]    gnt_q  [N_SLV];
  logic [MW-1:0]    gnt_d  [N_SLV];
  logic [MW-1:0]    rr_q   [N_SLV];
  logic [MW-1:0]    rr_d   [N_SLV];
  logic [MW-1:0]    fifo_q [N_SLV][N_MST];
  logic [MW-1:0]    wp_q   [N_SLV];
  logic [MW-1:0]    rp_q   [N_SLV];
  logic [CW-1:0]    cnt_q  [N_SLV];
  logic [SEL_W-1:0] psel_q [N_MST];
  logic [SEL_W-1:0] psel_d [N_MST];
  logic [SEL_W-1:0] sel    [N_MST];
  logic [N_MST-1:0] pend_q, pend_d;
  logic [N_SLV-1:0] push, pop;
`ifdef MS_ROUTER_DECERR_EN
  typedef enum logic [1:0] {E_IDLE, E_ACK, E_RESP} err_t;
  err_t          est_q, est_d;
  logic [MW-1:0] eg_q, eg_d, err_q, err_d;
`endif

  function automatic logic [MW-1:0] wrap(input logic [MW-1:0] b, input int k);
    logic [MW:0] s;
    s = {1'b0, b} + (MW+1)'(k);
    return (s >= (MW+1)'(N_MST)) ? MW'(s - (MW+1)'(N_MST)) : s[MW-1:0];
  endfunction

  // slave-select field of each master's address
  always_comb begin
    for (int i = 0; i < N_MST; i++) sel[i] = m_addr[i*ADDR_WIDTH+ADDR_WIDTH-1 -: SEL_W];
  end

  // per-slave round-robin arbitration, forwarding, read-id tracking and response routing
  always_comb begin
    logic [MW-1:0] g, id, idx;
    logic          any, act;
    m_ack   = '0;
    m_resp  = '0;
    m_rdata = '0;
    s_req   = '0;
    s_addr  = '0;
    s_cmd   = '0;
    s_wdata = '0;
    st_d    = st_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    pend_d  = pend_q;
    psel_d  = psel_q;
    push    = '0;
    pop     = '0;
    g       = '0;
    id      = '0;
    idx     = '0;
    any     = 1'b0;
    act     = 1'b0;
    for (int j = 0; j < N_SLV; j++) begin
      any = 1'b0;
      g   = gnt_q[j];
      for (int k = N_MST - 1; k >= 0; k--) begin
        idx = wrap(rr_q[j], k);
        if (m_req[idx] && sel[idx] == SEL_W'(j) &&
            (m_cmd[idx] || (!pend_q[idx] && cnt_q[j] != CW'(N_MST)))) begin
          any = 1'b1;
          g   = (st_q[j] == IDLE) ? idx : gnt_q[j];
        end
      end
      act      = (st_q[j] == IDLE) ? any : m_req[g];
      gnt_d[j] = g;
      s_req[j] = act;
      if (act) begin
        s_addr[j*ADDR_WIDTH +: ADDR_WIDTH]  = m_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        s_wdata[j*DATA_WIDTH +: DATA_WIDTH] = m_wdata[g*DATA_WIDTH +: DATA_WIDTH];
        s_cmd[j] = m_cmd[g];
      end
      st_d[j] = (act && !s_ack[j]) ? LOCKED : IDLE;
      if (s_resp[j] && cnt_q[j] != '0) begin
        pop[j] = 1'b1;
        id     = fifo_q[j][rp_q[j]];
        m_resp[id] = 1'b1;
        m_rdata[id*DATA_WIDTH +: DATA_WIDTH] = s_rdata[j*DATA_WIDTH +: DATA_WIDTH];
        if (psel_q[id] == SEL_W'(j)) pend_d[id] = 1'b0;
      end
      if (act && s_ack[j]) begin
        m_ack[g] = 1'b1;
        rr_d[j]  = wrap(g, 1);
        if (!m_cmd[g]) begin
          push[j]   = 1'b1;
          pend_d[g] = 1'b1;
          psel_d[g] = SEL_W'(j);
        end
      end
    end
`ifdef MS_ROUTER_DECERR_EN
    est_d = est_q;
    eg_d  = eg_q;
    err_d = err_q;
    any   = 1'b0;
    g     = eg_q;
    for (int k = N_MST - 1; k >= 0; k--) begin
      idx = wrap(err_q, k);
      if (m_req[idx] && {1'b0, sel[idx]} >= (SEL_W+1)'(N_SLV) && (m_cmd[idx] || !pend_q[idx])) begin
        any = 1'b1;
        g   = idx;
      end
    end
    if (est_q == E_IDLE && any) begin
      est_d = E_ACK;
      eg_d  = g;
    end
    if (est_q == E_ACK) begin
      est_d = (m_req[eg_q] && !m_cmd[eg_q]) ? E_RESP : E_IDLE;
      if (m_req[eg_q]) begin
        m_ack[eg_q] = 1'b1;
        err_d       = wrap(eg_q, 1);
        pend_d[eg_q] = pend_d[eg_q] | !m_cmd[eg_q];
      end
    end
    if (est_q == E_RESP) begin
      est_d        = E_IDLE;
      m_resp[eg_q] = 1'b1;
      m_rdata[eg_q*DATA_WIDTH +: DATA_WIDTH] = '1;
      pend_d[eg_q] = 1'b0;
    end
`endif
    if (rst) begin
      m_ack   = '0;
      m_resp  = '0;
      m_rdata = '0;
      s_req   = '0;
      s_addr  = '0;
      s_cmd   = '0;
      s_wdata = '0;
    end
  end

  // arbiter state, pointers, pending flags and id-fifo occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= '{default: IDLE};
      gnt_q  <= '{default: '0};
      rr_q   <= '{default: '0};
      wp_q   <= '{default: '0};
      rp_q   <= '{default: '0};
      cnt_q  <= '{default: '0};
      psel_q <= '{default: '0};
      pend_q <= '0;
    end else begin
      st_q   <= st_d;
      gnt_q  <= gnt_d;
      rr_q   <= rr_d;
      psel_q <= psel_d;
      pend_q <= pend_d;
      for (int j = 0; j < N_SLV; j++) begin
        if (push[j]) wp_q[j] <= wrap(wp_q[j], 1);
        if (pop[j]) rp_q[j] <= wrap(rp_q[j], 1);
        cnt_q[j] <= cnt_q[j] + CW'(push[j]) - CW'(pop[j]);
      end
    end
  end

  // id-fifo storage; validity is carried by the occupancy counters
  always_ff @(posedge clk) begin
    for (int j = 0; j < N_SLV; j++) if (push[j]) fifo_q[j][wp_q[j]] <= gnt_d[j];
  end

`ifdef MS_ROUTER_DECERR_EN
  // error-slave state: accept one cycle after request, read response one cycle after accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      est_q <= E_IDLE;
      eg_q  <= '0;
      err_q <= '0;
    end else begin
      est_q <= est_d;
      eg_q  <= eg_d;
      err_q <= err_d;
    end
  end
`endif
endmodule

// File: tb/tb_ms_router_nxm.sv
// tb_ms_router_nxm: directed bench with a response scoreboard for ms_router_nxm
module tb_ms_router_nxm;
  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   m_req, m_cmd, m_ack, m_resp;
  logic [63:0]  m_addr, m_wdata, m_rdata;
  logic [3:0]   s_req, s_cmd, s_ack, s_resp;
  logic [127:0] s_addr, s_wdata, s_rdata;
  logic [1:0]   b_m_req, b_m_cmd, b_m_ack, b_m_resp;
  logic [63:0]  b_m_addr, b_m_wdata, b_m_rdata;
  logic [2:0]   b_s_req, b_s_cmd;
  logic [95:0]  b_s_addr, b_s_wdata;
  logic [2:0]   b_s_ack  = '0;
  logic [2:0]   b_s_resp = '0;
  logic [95:0]  b_s_rdata = '0;
  int checks = 0;
  int errors = 0;
  int rr, g, acks;
  typedef struct {int m; logic [31:0] d;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  ms_router_nxm #(.N_MST(2), .N_SLV(4)) u_dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_addr(m_addr), .m_cmd(m_cmd), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .m_resp(m_resp), .s_req(s_req), .s_addr(s_addr),
    .s_cmd(s_cmd), .s_wdata(s_wdata), .s_ack(s_ack), .s_rdata(s_rdata), .s_resp(s_resp));

  ms_router_nxm #(.N_MST(2), .N_SLV(3)) u_d3 (
    .clk(clk), .rst(rst), .m_req(b_m_req), .m_addr(b_m_addr), .m_cmd(b_m_cmd), .m_wdata(b_m_wdata),
    .m_ack(b_m_ack), .m_rdata(b_m_rdata), .m_resp(b_m_resp), .s_req(b_s_req), .s_addr(b_s_addr),
    .s_cmd(b_s_cmd), .s_wdata(b_s_wdata), .s_ack(b_s_ack), .s_rdata(b_s_rdata), .s_resp(b_s_resp));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int m, input logic req, input logic [31:0] addr, input logic cmd, input logic [31:0] wd);
    m_req[m] = req;
    m_addr[m*32 +: 32] = addr;
    m_cmd[m] = cmd;
    m_wdata[m*32 +: 32] = wd;
  endtask

  task automatic exp_push(input int m, input logic [31:0] d);
    exp_t e;
    e.m = m;
    e.d = d;
    sb.push_back(e);
  endtask

  task automatic resp_chk(input string tag);
    exp_t e;
    int n = 0;
    while (m_resp == 2'b00 && n < 10) begin
      step();
      #1;
      n++;
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, m_resp, 128'h0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_resp"}, m_resp, 128'(1) << e.m);
      chk({tag, "_rdata"}, m_rdata[e.m*32 +: 32], e.d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    m_req = '0; m_cmd = '0; m_addr = '0; m_wdata = '0;
    s_ack = '0; s_resp = '0; s_rdata = '0;
    b_m_req = '0; b_m_cmd = '0; b_m_addr = '0; b_m_wdata = '0;
    m_req = 2'b01;
    s_ack = '1;
    #3;
    chk("rst_s_req", s_req, 0);
    chk("rst_m_ack", m_ack, 0);
    chk("rst_s_addr", s_addr, 0);
    m_req = '0;
    s_ack = '0;
    step(); step();
    rst = 1'b0;
    step();
    // single write, slave 1 accepts immediately
    drv(0, 1, 32'h4000_0010, 1, 32'h1234_5678);
    s_ack[1] = 1'b1;
    #1;
    chk("wr_s_req", s_req, 4'b0010);
    chk("wr_s_addr", s_addr[63:32], 32'h4000_0010);
    chk("wr_s_wdata", s_wdata[63:32], 32'h1234_5678);
    chk("wr_s_cmd", s_cmd[1], 1);
    chk("wr_m_ack", m_ack, 2'b01);
    chk("wr_no_resp", m_resp, 0);
    step();
    drv(0, 0, 0, 0, 0);
    s_ack = '0;
    #1;
    chk("wr_ack_once", m_ack, 0);
    step();
    // two reads contend for slave 2, slave accepts on the fourth cycle of each
    drv(0, 1, 32'h8000_0000, 0, 0);
    drv(1, 1, 32'h8000_0004, 0, 0);
    #1;
    chk("rd2_s_req", s_req, 4'b0100);
    chk("rd2_first_m0", s_addr[95:64], 32'h8000_0000);
    step(); step();
    #1;
    chk("rd2_locked_m0", s_addr[95:64], 32'h8000_0000);
    chk("rd2_wait_ack", m_ack, 0);
    step();
    s_ack[2] = 1'b1;
    #1;
    chk("rd2_ack_m0", m_ack, 2'b01);
    exp_push(0, 32'hAAAA_0000);
    step();
    m_req[0] = 1'b0;
    s_ack = '0;
    #1;
    chk("rd2_then_m1", s_addr[95:64], 32'h8000_0004);
    step(); step(); step();
    s_ack[2] = 1'b1;
    #1;
    chk("rd2_ack_m1", m_ack, 2'b10);
    exp_push(1, 32'hBBBB_0000);
    step();
    m_req = '0;
    s_ack = '0;
    s_resp[2] = 1'b1;
    s_rdata[95:64] = 32'hAAAA_0000;
    #1;
    resp_chk("rd2_r0");
    step();
    s_rdata[95:64] = 32'hBBBB_0000;
    #1;
    resp_chk("rd2_r1");
    step();
    s_resp = '0;
    // continuous writes to slave 0 from both masters
    drv(0, 1, 32'h0000_0000, 1, 32'h1);
    drv(1, 1, 32'h0000_0100, 1, 32'h2);
    s_ack[0] = 1'b1;
    rr = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      g = rr;
      chk($sformatf("rr_grant%0d", k), m_ack, 128'(1) << g);
      rr = (g + 1) % 2;
      step();
    end
    #1;
    chk("rr_ptr_back_to_0", m_ack, 128'(1) << rr);
    step();
    m_req = '0;
    s_ack = '0;
    step();
    // second read blocked while the first is outstanding
    drv(0, 1, 32'h4000_0000, 0, 0);
    s_ack[1] = 1'b1;
    #1;
    chk("pend_rd1_ack", m_ack, 2'b01);
    exp_push(0, 32'hCCCC_0001);
    step();
    drv(0, 1, 32'hC000_0000, 0, 0);
    s_ack = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("pend_block%0d", k), s_req[3], 0);
      step();
    end
    s_resp[1] = 1'b1;
    s_rdata[63:32] = 32'hCCCC_0001;
    #1;
    resp_chk("pend_r1");
    chk("pend_block_resp_cycle", s_req[3], 0);
    step();
    s_resp = '0;
    #1;
    chk("pend_fwd", s_req[3], 1);
    chk("pend_fwd_ack", m_ack, 2'b01);
    exp_push(0, 32'hDDDD_0003);
    step();
    m_req = '0;
    s_ack = '0;
    s_resp[3] = 1'b1;
    s_rdata[127:96] = 32'hDDDD_0003;
    #1;
    resp_chk("pend_r3");
    step();
    s_resp = '0;
    // reset while slave 0 is locked with one read id queued
    drv(0, 1, 32'h0000_0000, 0, 0);
    s_ack[0] = 1'b1;
    #1;
    chk("rst_mid_push", m_ack, 2'b01);
    step();
    m_req[0] = 1'b0;
    drv(1, 1, 32'h0000_0040, 0, 0);
    s_ack = '0;
    #1;
    chk("rst_mid_req", s_req, 4'b0001);
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_s_req", s_req, 0);
    chk("rst_async_s_addr", s_addr, 0);
    chk("rst_async_m_ack", m_ack, 0);
    chk("rst_async_m_resp", m_resp, 0);
    m_req = '0;
    step(); step();
    rst = 1'b0;
    step();
    s_resp[0] = 1'b1;
    s_rdata[31:0] = 32'h5555_5555;
    #1;
    chk("stray_resp", m_resp, 0);
    chk("stray_rdata", m_rdata, 0);
    step();
    s_resp = '0;
    drv(0, 1, 32'h4000_0000, 0, 0);
    s_ack[1] = 1'b1;
    #1;
    chk("rst_clears_pending", m_ack, 2'b01);
    step();
    m_req = '0;
    s_ack = '0;
    // out-of-range read on a three-slave router
    b_m_req[0] = 1'b1;
    b_m_addr[31:0] = 32'hC000_0000;
    b_m_cmd[0] = 1'b0;
`ifdef MS_ROUTER_DECERR_EN
    #1;
    chk("derr_no_ack_yet", b_m_ack, 0);
    step();
    #1;
    chk("derr_ack", b_m_ack, 2'b01);
    step();
    b_m_req = '0;
    #1;
    chk("derr_resp", b_m_resp, 2'b01);
    chk("derr_rdata", b_m_rdata[31:0], 32'hFFFF_FFFF);
`else
    acks = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      acks += int'(b_m_ack[0]);
      step();
    end
    chk("oor_never_acked", acks, 0);
    chk("oor_no_slave_req", b_s_req, 0);
    b_m_req = '0;
`endif
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ms_router_nxm.md
Name: ms_router_nxm

Overview:
- Parametrised N-master to M-slave crossbar for the team's req/ack/resp master-slave bus.
- Decodes the slave from the upper address bits and arbitrates each slave round-robin.
- Tracks outstanding reads so every rdata/resp pulse is routed back to the master that issued the read.
- Sits between CPU-side masters and peripheral slaves; successor to the fixed two-port router.

Parameters:
N_MST, 2, number of master ports (2..8)
N_SLV, 4, number of slave ports (2..8)
DATA_WIDTH, 32, wdata/rdata width
ADDR_WIDTH, 32, address width
SEL_W, $clog2(N_SLV), slave-select field width, taken from addr[ADDR_WIDTH-1 -: SEL_W]

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
m_req  in  N_MST  master request
m_addr  in  N_MST*ADDR_WIDTH  master address, flattened, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
m_cmd  in  N_MST  0 read, 1 write
m_wdata  in  N_MST*DATA_WIDTH  master write data
m_ack  out  N_MST  request accepted
m_rdata  out  N_MST*DATA_WIDTH  read data to master
m_resp  out  N_MST  read data valid
s_req  out  N_SLV  slave request
s_addr  out  N_SLV*ADDR_WIDTH  forwarded address
s_cmd  out  N_SLV  forwarded command
s_wdata  out  N_SLV*DATA_WIDTH  forwarded write data
s_ack  in  N_SLV  slave accept
s_rdata  in  N_SLV*DATA_WIDTH  slave read data
s_resp  in  N_SLV  slave read data valid

Behaviour:
- Clocking and reset: single clock `clk`. Reset `rst` is asynchronous and active-high.
- Reset state: all grant locks clear; round-robin pointers = 0; ID FIFOs empty; per-master pending flags = 0.
- Outputs during reset: m_ack, m_resp, s_req = 0; m_rdata, s_addr, s_cmd, s_wdata = 0.
- Bus protocol:
  - A master holds req/addr/cmd/wdata stable until it sees a one-cycle ack.
  - Each slave returns reads in order, one resp pulse per read.
- Decode: sel = addr[ADDR_WIDTH-1 -: SEL_W]. sel >= N_SLV is out-of-range (see Optional Feature).
- Eligibility: master i is eligible for slave j when all of the following hold:
  - m_req[i] = 1 and sel = j;
  - for reads, pending[i] = 0 and the ID FIFO of slave j is not full.
- Per-slave arbiter, states IDLE / LOCKED:
  - IDLE: grant = first eligible master at or after rr_ptr[j], chosen combinationally. s_req[j] is driven in the same cycle (zero-latency forward). If s_ack[j] = 0, go to LOCKED holding the grant.
  - LOCKED: grant is held regardless of other requesters. Return to IDLE on s_ack[j].
  - On s_ack[j]: m_ack[grant] = s_ack[j] combinationally, and rr_ptr[j] <= grant+1 mod N_MST.
- Read tracking, on an accepted read (ack with cmd = 0):
  - Push the master index into the ID FIFO of slave j; depth N_MST, width $clog2(N_MST).
  - Set pending[i] and store slave index psel[i].
  - A master therefore has at most one outstanding read, so response collisions at a master are impossible.
- Response routing, on s_resp[j]:
  - Pop FIFO j and drive m_resp/m_rdata of the popped master combinationally from s_rdata[j].
  - Clear pending for that master.
- s_resp[j] with FIFO j empty is a protocol error: ignored, and no m_resp is generated.
- Same-cycle push and pop on one FIFO are both performed; occupancy is unchanged.
- Writes: no tracking. The ack completes the transfer.
- m_rdata of a master with no resp this cycle = 0.
- A master whose req drops before ack is a protocol violation. The router releases the lock next cycle without updating rr_ptr.
- Reset mid-transaction: all outstanding reads are discarded. Late s_resp pulses after reset hit empty FIFOs and are ignored.

Optional Feature:
Macro MS_ROUTER_DECERR_EN.
- Defined: an out-of-range request is acked by an internal error slave one cycle after req is seen.
  - Reads additionally get m_resp with m_rdata = all ones in the cycle after the ack.
  - The error slave is arbitrated round-robin like a real slave and serves one request at a time.
- Undefined: an out-of-range request is never forwarded and never acked (master stalls), and no error logic is synthesised.

Test Plan:
- N_MST=2, N_SLV=4: M0 writes addr 0x4000_0010 (sel 1), slave 1 acks immediately -> s_req[1] and s_wdata[1] match in the same cycle, m_ack[0] pulses once, no m_resp.
- M0 and M1 both read slave 2 in the same cycle, slave acks after 3 cycles each -> M0 served first (rr_ptr=0), then M1. Responses 0xAAAA_0000 and 0xBBBB_0000 arrive in that order at m_rdata[0] and m_rdata[1] respectively.
- M0 and M1 request slave 0 continuously for 8 grants -> grants alternate 0,1,0,1. rr_ptr ends at 0.
- M0 read to slave 1 outstanding (no resp), M0 issues a second read to slave 3 -> s_req[3] stays 0 until slave 1 resp, then forwards.
- Assert rst while slave 0 is LOCKED and FIFO holds 1 entry -> all outputs 0 asynchronously. After release, a stray s_resp[0] produces no m_resp.
- With MS_ROUTER_DECERR_EN and N_SLV=3: read addr 0xC000_0000 -> m_ack one cycle later, then m_resp with m_rdata=0xFFFF_FFFF. Without the macro -> no ack for 20 cycles.
